// File: rtl/hilo_muldiv_unit.sv
// HI/LO register pair with MULT/MULTU/DIV/DIVU/MTHI/MTLO execution.
// Divide is an iterative restoring divider; multiply is iterative or single-cycle.
module hilo_muldiv_unit #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MUL_MODE = 0,
  parameter int unsigned CNT_W    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_in,
  input  logic [WIDTH-1:0] rt_in,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [WIDTH-1:0]     hi_q, lo_q;
  logic                 busy_q, done_q, dbz_q;
  // Mul: {partial sum, multiplier}; div: {remainder, quotient}.
  logic [2*WIDTH-1:0]   p_q;
  logic [WIDTH-1:0]     opb_q;
  logic                 is_div_q, neg_q, rem_neg_q;

  logic                 is_signed, a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [2*WIDTH-1:0]   prod_full, fast_prod;
  logic [WIDTH:0]       mul_sum, div_rsh, div_trial;
  logic [2*WIDTH-1:0]   mul_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  always_comb begin
    is_signed = ~op[0];
    a_neg     = is_signed & rs_in[WIDTH-1];
    b_neg     = is_signed & rt_in[WIDTH-1];
    a_mag     = a_neg ? -rs_in : rs_in;
    b_mag     = b_neg ? -rt_in : rt_in;
    prod_full = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
    fast_prod = (a_neg ^ b_neg) ? -prod_full : prod_full;

    mul_sum   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, opb_q} : '0);
    div_rsh   = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    div_trial = div_rsh - {1'b0, opb_q};

    mul_fix   = neg_q ? -p_q : p_q;
    quo_fix   = neg_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
    rem_fix   = rem_neg_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      p_q       <= '0;
      opb_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // abort on the accepting edge drops the start
          if (start && !abort) begin
            case (op)
              3'b100: begin
                hi_q   <= rs_in;
                done_q <= 1'b1;
              end
              3'b101: begin
                lo_q   <= rs_in;
                done_q <= 1'b1;
              end
              3'b000, 3'b001: begin
                if (MUL_MODE == 1) begin
                  {hi_q, lo_q} <= fast_prod;
                  done_q       <= 1'b1;
                end else begin
                  p_q      <= {{WIDTH{1'b0}}, a_mag};
                  opb_q    <= b_mag;
                  is_div_q <= 1'b0;
                  neg_q    <= a_neg ^ b_neg;
                  cnt_q    <= CNT_W'(WIDTH - 1);
                  busy_q   <= 1'b1;
                  state_q  <= StRun;
                end
              end
              3'b010, 3'b011: begin
                if (rt_in == '0) begin
                  done_q <= 1'b1;
                  dbz_q  <= 1'b1;
                end else begin
                  p_q       <= {{WIDTH{1'b0}}, a_mag};
                  opb_q     <= b_mag;
                  is_div_q  <= 1'b1;
                  neg_q     <= a_neg ^ b_neg;
                  rem_neg_q <= a_neg;
                  cnt_q     <= CNT_W'(WIDTH - 1);
                  busy_q    <= 1'b1;
                  state_q   <= StRun;
                end
              end
              default: ;
            endcase
          end
        end
        StRun: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            if (is_div_q) begin
              p_q[2*WIDTH-1:WIDTH] <= div_trial[WIDTH] ? div_rsh[WIDTH-1:0]
                                                       : div_trial[WIDTH-1:0];
              p_q[WIDTH-1:0]       <= {p_q[WIDTH-2:0], ~div_trial[WIDTH]};
            end else begin
              p_q <= {mul_sum, p_q[WIDTH-1:1]};
            end
            if (cnt_q == '0) state_q <= StFix;
            else             cnt_q   <= cnt_q - 1'b1;
          end
        end
        StFix: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
          if (!abort) begin
            if (is_div_q) begin
              lo_q <= quo_fix;
              hi_q <= rem_fix;
            end else begin
              {hi_q, lo_q} <= mul_fix;
            end
            done_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi_out      = hi_q;
  assign lo_out      = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: iterative instance (u0) and single-cycle multiply (u1).
module tb_hilo_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [2:0]  op = 3'b111;
  logic [31:0] rs = '0, rt = '0;
  logic        abort = 1'b0;
  logic        busy0, done0, dbz0, busy1, done1, dbz1;
  logic [31:0] hi0, lo0, hi1, lo1;

  int vectors = 0;
  int miscompares = 0;
  int cycles;
  int pulses;

  hilo_muldiv_unit #(.WIDTH(32), .MUL_MODE(0)) u0 (
    .clk(clk), .rst(rst), .start(start0), .op(op), .rs_in(rs), .rt_in(rt), .abort(abort),
    .busy(busy0), .done(done0), .div_by_zero(dbz0), .hi_out(hi0), .lo_out(lo0)
  );

  hilo_muldiv_unit #(.WIDTH(32), .MUL_MODE(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .op(op), .rs_in(rs), .rt_in(rt), .abort(abort),
    .busy(busy1), .done(done1), .div_by_zero(dbz1), .hi_out(hi1), .lo_out(lo1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input bit which, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b);
    op = o; rs = a; rt = b;
    if (which) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0; op = 3'b111;
  endtask

  task automatic wait_done0(output int busy_cycles);
    int guard;
    busy_cycles = 0;
    guard = 0;
    while (!done0 && guard < 100) begin
      if (busy0) busy_cycles++;
      guard++;
      @(negedge clk);
    end
  endtask

  initial begin
    @(negedge clk);
    chk("rst_hi", {32'b0, hi0}, 64'h0);
    chk("rst_lo", {32'b0, lo0}, 64'h0);
    chk("rst_flags", {61'b0, busy0, done0, dbz0}, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    issue(0, 3'b001, 32'hFFFF_FFFF, 32'h0000_0002);
    wait_done0(cycles);
    chk("multu_busy_cycles", 64'(cycles), 64'd33);
    chk("multu_done", {63'b0, done0}, 64'h1);
    chk("multu_hilo", {hi0, lo0}, 64'h0000_0001_FFFF_FFFE);
    @(negedge clk);
    chk("multu_done_pulse", {63'b0, done0}, 64'h0);

    issue(0, 3'b000, 32'hFFFF_FFFD, 32'h0000_0007);
    wait_done0(cycles);
    chk("mult_hilo", {hi0, lo0}, 64'hFFFF_FFFF_FFFF_FFEB);
    @(negedge clk);

    issue(1, 3'b000, 32'hFFFF_FFFD, 32'h0000_0007);
    chk("fastmul_done_busy", {62'b0, done1, busy1}, 64'h2);
    chk("fastmul_hilo", {hi1, lo1}, 64'hFFFF_FFFF_FFFF_FFEB);
    @(negedge clk);

    issue(0, 3'b010, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_done0(cycles);
    chk("div_neg_hilo", {hi0, lo0}, 64'hFFFF_FFFF_FFFF_FFFD);
    @(negedge clk);

    issue(0, 3'b011, 32'd100, 32'd7);
    wait_done0(cycles);
    chk("divu_hilo", {hi0, lo0}, {32'd2, 32'd14});
    @(negedge clk);

    issue(0, 3'b010, 32'h1234_5678, 32'h0);
    chk("dbz_flags", {61'b0, busy0, done0, dbz0}, 64'h3);
    chk("dbz_hilo_kept", {hi0, lo0}, {32'd2, 32'd14});
    @(negedge clk);
    chk("dbz_flag_clear", {62'b0, done0, dbz0}, 64'h0);

    issue(0, 3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done0(cycles);
    chk("div_ovf_hilo", {hi0, lo0}, 64'h0000_0000_8000_0000);
    @(negedge clk);

    issue(0, 3'b100, 32'hA5A5_A5A5, 32'h0);
    chk("mthi", {61'b0, busy0, done0, 1'b0}, 64'h2);
    chk("mthi_hi", {32'b0, hi0}, 64'hA5A5_A5A5);
    issue(0, 3'b101, 32'h5A5A_5A5A, 32'h0);
    chk("mtlo_done", {63'b0, done0}, 64'h1);
    chk("mtlo_lo", {32'b0, lo0}, 64'h5A5A_5A5A);
    @(negedge clk);

    issue(0, 3'b011, 32'd50, 32'd5);
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", {63'b0, busy0}, 64'h0);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done0) pulses++;
    end
    chk("abort_no_done", 64'(pulses), 64'd0);
    chk("abort_hilo_kept", {hi0, lo0}, 64'hA5A5_A5A5_5A5A_5A5A);

    issue(0, 3'b011, 32'd50, 32'd7);
    start0 = 1'b1; op = 3'b100; rs = 32'hDEAD_BEEF;
    @(negedge clk);
    start0 = 1'b0; op = 3'b111;
    chk("busy_start_still_busy", {63'b0, busy0}, 64'h1);
    wait_done0(cycles);
    chk("busy_start_ignored", {hi0, lo0}, {32'd1, 32'd7});
    @(negedge clk);

    issue(0, 3'b011, 32'd1000, 32'd3);
    repeat (5) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_hilo", {hi0, lo0}, 64'h0);
    chk("async_rst_flags", {61'b0, busy0, done0, dbz0}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done0 || busy0) pulses++;
    end
    chk("rst_no_done", 64'(pulses), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Parametrised successor to the current combinational MULT/MULTU/DIV/DIVU cores and their HI/LO register pair.
- Owns HI and LO and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO on operands from the CPU.
- Multiply can be iterative or single-cycle; divide is always an iterative restoring divider, so no second clock is needed.
- Provides a busy/done handshake, divide-by-zero flagging, and an abort input for exception flush.

Parameters:
- WIDTH, 32: operand width; HI and LO are WIDTH bits each.
- MUL_MODE, 0: 0 = iterative shift-add multiply (WIDTH iterations); 1 = single-cycle multiply.
- CNT_W, $clog2(WIDTH)+1: iteration counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  launch op; sampled on rising clk.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 11x ignored (no effect).
- rs_in  in  WIDTH  operand A (multiplicand/dividend; MTHI/MTLO source).
- rt_in  in  WIDTH  operand B (multiplier/divisor).
- abort  in  1  kill in-flight op (exception/eret flush).
- busy  out  1  iterative op in progress.
- done  out  1  one-cycle pulse: HI/LO updated, or div-by-zero reported.
- div_by_zero  out  1  valid with done; divisor was 0.
- hi_out  out  WIDTH  HI register.
- lo_out  out  WIDTH  LO register.

Behaviour:
- Reset (async, rst=1): HI=0, LO=0, busy=0, done=0, div_by_zero=0, FSM=IDLE, counter=0. Reset mid-operation discards the op immediately.
- FSM states: IDLE, RUN, FIX.
- start is accepted only in IDLE. start while busy is ignored; the CPU must stall on busy.
- Operands are latched at the accepting edge (E0). rs_in/rt_in may change afterwards.
- MTHI/MTLO: at E0, HI (or LO) <= rs_in. done=1 for the following cycle; busy never asserts.
- MULT/DIV (signed): operands are converted to magnitudes at E0, and the result signs are recorded:
  - MULT product sign = sign(A)^sign(B).
  - DIV quotient sign = sign(A)^sign(B).
  - DIV remainder sign = sign(A).
- MULTU/DIVU: no sign handling.
- Iterative op (any DIV/DIVU; MULT/MULTU when MUL_MODE=0):
  - IDLE->RUN at E0; busy=1 from E0.
  - RUN performs one iteration per edge E1..E_WIDTH. The counter counts WIDTH-1 down to 0; RUN->FIX when counter==0.
  - FIX at E_{WIDTH+1}: apply sign correction (two's complement of the 2*WIDTH product, or separately of quotient and remainder), write HI/LO, go FIX->IDLE.
  - After E_{WIDTH+1}: busy=0 and done=1 for one cycle.
  - A new start is accepted in the cycle done is high.
- Multiply result: HI = product[2W-1:W], LO = product[W-1:0].
- Divide result: LO = quotient, HI = remainder.
- MUL_MODE=1 MULT/MULTU: full product computed combinationally and written to HI/LO at E0; done the next cycle; busy stays 0.
- Divide by zero (rt_in==0 at E0): no iteration; HI/LO unchanged. done=1 and div_by_zero=1 for the cycle after E0; busy stays 0.
- Signed overflow (DIV of 0x80000000 by 0xFFFFFFFF, WIDTH=32): LO=0x80000000, HI=0. Magnitude arithmetic wraps naturally; this needs no special case.
- abort=1 in RUN or FIX: go to IDLE at the next edge, HI/LO unchanged, no done pulse.
  - abort in IDLE has no effect.
  - abort and start on the same edge: abort wins, start is dropped.
- done and div_by_zero are registered; both are cleared on every edge where they are not re-asserted.
- hi_out/lo_out are driven directly from the registers and hold their values while busy.

Test Plan:
- Reset, then MULTU rs=0xFFFFFFFF, rt=0x00000002 (MUL_MODE=0) -> busy for 33 cycles; done pulses; HI=0x00000001, LO=0xFFFFFFFE.
- MULT rs=0xFFFFFFFD (-3), rt=0x00000007 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21). Repeat with MUL_MODE=1 -> same values, done 1 cycle after start, busy never high.
- DIV rs=0xFFFFFFF9 (-7), rt=0x00000002 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU rs=100, rt=7 -> LO=14, HI=2.
- DIV rs=0x12345678, rt=0 -> one cycle later done=1 and div_by_zero=1; HI/LO keep their previous values; busy stays 0. Then DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI 0xA5A5A5A5, then MTLO 0x5A5A5A5A -> each visible one cycle later with done. Start DIVU 50/5, assert abort at iteration 10 -> IDLE, no done, HI/LO still 0xA5A5A5A5/0x5A5A5A5A.
- Start DIVU, pulse start again while busy with MTHI -> second start ignored, HI = remainder only. Assert rst mid-RUN -> all outputs 0 immediately (asynchronous), no done after release.
